// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file sequencer.
// Contents: the FSM state type, opcode constants, instruction field positions
// and a helper that says whether a decoded instruction writes a register.
package regfile_ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  // Instruction field positions: op[15:12] rdest[11:8] opext[7:4] rsrc[3:0], imm[7:0]
  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 8;
  localparam int OPX_LSB  = 4;
  localparam int RS_LSB   = 0;
  localparam int IMM_LSB  = 0;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [FIELD_W-1:0] OP_CMPI  = 4'hB;
  localparam logic [FIELD_W-1:0] OPX_CMP  = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  // NOP, CMP and CMPI retire without touching the register file.
  function automatic logic is_no_write(input logic [INSTR_W-1:0] word);
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] opx;
    op  = word[OP_LSB +: FIELD_W];
    opx = word[OPX_LSB +: FIELD_W];
    return (word == '0) ||
           ((op == OP_RTYPE) && (opx == OPX_CMP)) ||
           (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bundle of the sequencer's instruction handshake, external-writer arbitration
// and register-file control signals.
//   slave  : the controller side (regfile_ctrl)
//   master : the environment side (instruction source, ALU, external writer,
//            register file)
interface regfile_ctrl_if
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);

  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                alu_ready;
  logic                ext_wr_req;
  logic [ADDR_W-1:0]   ext_wr_addr;
  logic                ext_wr_grant;
  logic [ADDR_W-1:0]   rd_sel_a;
  logic [ADDR_W-1:0]   rd_sel_b;
  logic                imm_sel;
  logic [IMM_W-1:0]    imm;
  logic [7:0]          alu_op;
  logic                bus_sel;
  logic [NUM_REGS-1:0] reg_enable;
  logic                done;

  modport slave (
    input  instr, instr_valid, alu_ready, ext_wr_req, ext_wr_addr,
    output instr_ready, ext_wr_grant, rd_sel_a, rd_sel_b, imm_sel, imm,
           alu_op, bus_sel, reg_enable, done
  );

  modport master (
    output instr, instr_valid, alu_ready, ext_wr_req, ext_wr_addr,
    input  instr_ready, ext_wr_grant, rd_sel_a, rd_sel_b, imm_sel, imm,
           alu_op, bus_sel, reg_enable, done
  );

endinterface

// File: rtl/regfile_onehot_dec.sv
// Address-to-one-hot decoder for the register write strobes.
//   addr_i   : register address
//   en_i     : strobe enable; output is all zero when low
//   onehot_o : at most one bit set; zero when addr_i >= NUM_REGS
module regfile_onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  // Comparing every output index against the address keeps out-of-range
  // addresses naturally mapped to an all-zero strobe.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = en_i && (addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle sequencer for the register file.
// Accepts one instruction per handshake, drives operand selects / ALU op /
// immediate, then pulses a one-hot register write enable in WB. Between
// instructions (IDLE) an external writer may take the write bus.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : regfile_ctrl_if.slave (handshake, arbitration and control outputs)
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  regfile_ctrl_if.slave bus
);

  state_t state_q, state_d;

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  rd_sel_a_q, rd_sel_b_q;
  logic               imm_sel_q;
  logic [IMM_W-1:0]   imm_q;
  logic [7:0]         alu_op_q;

  logic               accept;
  logic               instr_ready;
  logic               ext_grant;
  logic               bus_sel;
  logic               done;
  logic [ADDR_W-1:0]  dec_addr;
  logic               dec_en;
  logic [NUM_REGS-1:0] onehot;

  logic [FIELD_W-1:0] in_op, in_opx, q_rdest;
  logic               rdest_in_range;

  assign in_op   = bus.instr[OP_LSB +: FIELD_W];
  assign in_opx  = bus.instr[OPX_LSB +: FIELD_W];
  assign q_rdest = instr_q[RD_LSB +: FIELD_W];

  // rdest bits above ADDR_W address registers that do not exist.
  assign rdest_in_range = ((q_rdest >> ADDR_W) == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand selects are captured on the accept edge, so they are already
  // valid during DECODE and hold until the next accepted instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= '0;
      rd_sel_a_q <= '0;
      rd_sel_b_q <= '0;
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
      alu_op_q   <= '0;
    end else if (accept) begin
      instr_q    <= bus.instr;
      rd_sel_a_q <= ADDR_W'(bus.instr[RD_LSB +: FIELD_W]);
      rd_sel_b_q <= ADDR_W'(bus.instr[RS_LSB +: FIELD_W]);
      imm_sel_q  <= (in_op != OP_RTYPE);
      imm_q      <= bus.instr[IMM_LSB +: IMM_W];
      alu_op_q   <= (in_op == OP_RTYPE) ? {in_op, in_opx} : {in_op, 4'h0};
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    ext_grant   = 1'b0;
    bus_sel     = 1'b0;
    done        = 1'b0;
    dec_addr    = bus.ext_wr_addr;
    dec_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gating with reset keeps every output low while reset is held,
        // even though the state register already reads IDLE.
        if (reset) begin
          if (bus.ext_wr_req) begin
            ext_grant = 1'b1;
            bus_sel   = 1'b1;
            dec_en    = 1'b1;
          end else begin
            instr_ready = 1'b1;
            accept      = bus.instr_valid;
            if (bus.instr_valid) state_d = DECODE;
          end
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (bus.alu_ready) state_d = WB;
      end
      WB: begin
        done     = 1'b1;
        dec_addr = ADDR_W'(q_rdest);
        dec_en   = rdest_in_range && !is_no_write(instr_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  regfile_onehot_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dec (
    .addr_i   (dec_addr),
    .en_i     (dec_en),
    .onehot_o (onehot)
  );

  assign bus.instr_ready  = instr_ready;
  assign bus.ext_wr_grant = ext_grant;
  assign bus.bus_sel      = bus_sel;
  assign bus.done         = done;
  assign bus.reg_enable   = onehot;
  assign bus.rd_sel_a     = rd_sel_a_q;
  assign bus.rd_sel_b     = rd_sel_b_q;
  assign bus.imm_sel      = imm_sel_q;
  assign bus.imm          = imm_q;
  assign bus.alu_op       = alu_op_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: reset, R-type, immediate with ALU stall,
// no-write instructions, external-writer arbitration and mid-flight reset.
module tb_regfile_ctrl;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_ctrl_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) bus ();

  regfile_ctrl #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one instruction from IDLE with a single-cycle ALU and watch the
  // following six cycles, collecting every write strobe and done pulse.
  task automatic run_instr(input logic [15:0] word, output logic [15:0] en_seen,
                           output int done_cnt);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    bus.alu_ready   = 1'b1;
    #1;
    check("run_accept_ready", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    en_seen  = '0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      en_seen = en_seen | bus.reg_enable;
      if (bus.done) done_cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] en_seen;
    int          done_cnt;

    reset           = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.alu_ready   = 1'b1;
    bus.ext_wr_req  = 1'b0;
    bus.ext_wr_addr = '0;

    // Reset held: everything low, even with a request present.
    repeat (2) tick();
    check("rst_instr_ready", bus.instr_ready, 0);
    check("rst_reg_enable", bus.reg_enable, 0);
    bus.ext_wr_req  = 1'b1;
    bus.ext_wr_addr = 4'h5;
    #1;
    check("rst_ext_grant", bus.ext_wr_grant, 0);
    check("rst_ext_reg_enable", bus.reg_enable, 0);
    bus.ext_wr_req = 1'b0;

    // Release, idle.
    reset = 1'b1;
    #1;
    check("idle_instr_ready", bus.instr_ready, 1);
    check("idle_done", bus.done, 0);
    check("idle_bus_sel", bus.bus_sel, 0);
    check("idle_grant", bus.ext_wr_grant, 0);
    check("idle_alu_op", bus.alu_op, 0);
    check("idle_rd_sel_a", bus.rd_sel_a, 0);
    tick();

    // R-type 0352: op 0, rdest 3, opext 5, rsrc 2.
    bus.instr       = 16'h0352;
    bus.instr_valid = 1'b1;
    bus.alu_ready   = 1'b1;
    #1;
    check("r_ready", bus.instr_ready, 1);
    tick();                                     // T+1 DECODE
    bus.instr_valid = 1'b0;
    check("r_rd_sel_a", bus.rd_sel_a, 3);
    check("r_rd_sel_b", bus.rd_sel_b, 2);
    check("r_alu_op", bus.alu_op, 8'h05);
    check("r_imm_sel", bus.imm_sel, 0);
    check("r_dec_ready", bus.instr_ready, 0);
    check("r_dec_enable", bus.reg_enable, 0);
    tick();                                     // T+2 EXEC
    check("r_exec_enable", bus.reg_enable, 0);
    check("r_exec_done", bus.done, 0);
    tick();                                     // T+3 WB
    check("r_wb_enable", bus.reg_enable, 16'h0008);
    check("r_wb_done", bus.done, 1);
    check("r_wb_bus_sel", bus.bus_sel, 0);
    tick();                                     // back to IDLE
    check("r_post_done", bus.done, 0);
    check("r_post_enable", bus.reg_enable, 0);
    check("r_post_ready", bus.instr_ready, 1);

    // Immediate 57A4 with ALU stalled for three EXEC cycles.
    bus.instr       = 16'h57A4;
    bus.instr_valid = 1'b1;
    bus.alu_ready   = 1'b0;
    tick();                                     // T+1 DECODE
    bus.instr_valid = 1'b0;
    check("i_imm_sel", bus.imm_sel, 1);
    check("i_imm", bus.imm, 8'hA4);
    check("i_alu_op", bus.alu_op, 8'h50);
    check("i_rd_sel_a", bus.rd_sel_a, 7);
    for (int i = 0; i < 3; i++) begin           // T+2..T+4 EXEC, stalled
      tick();
      check("i_stall_done", bus.done, 0);
      check("i_stall_enable", bus.reg_enable, 0);
    end
    tick();                                     // T+5 fourth EXEC cycle
    bus.alu_ready = 1'b1;
    #1;
    check("i_exec4_done", bus.done, 0);
    tick();                                     // T+6 WB
    check("i_wb_enable", bus.reg_enable, 16'h0080);
    check("i_wb_done", bus.done, 1);
    tick();
    check("i_post_enable", bus.reg_enable, 0);

    // No-write instructions: CMPI, CMP (R-type opext B), NOP.
    run_instr(16'hB120, en_seen, done_cnt);
    check("cmpi_enable", en_seen, 0);
    check("cmpi_done", done_cnt, 1);
    run_instr(16'h02B1, en_seen, done_cnt);
    check("cmp_enable", en_seen, 0);
    check("cmp_done", done_cnt, 1);
    run_instr(16'h0000, en_seen, done_cnt);
    check("nop_enable", en_seen, 0);
    check("nop_done", done_cnt, 1);
    // Writing R-type with opext next to CMP still writes.
    run_instr(16'h0CA1, en_seen, done_cnt);
    check("rA_enable", en_seen, 16'h1000);
    check("rA_done", done_cnt, 1);

    // External write competes with an instruction in IDLE.
    bus.ext_wr_req  = 1'b1;
    bus.ext_wr_addr = 4'hF;
    bus.instr       = 16'h1234;
    bus.instr_valid = 1'b1;
    bus.alu_ready   = 1'b1;
    #1;
    check("arb_grant", bus.ext_wr_grant, 1);
    check("arb_bus_sel", bus.bus_sel, 1);
    check("arb_enable", bus.reg_enable, 16'h8000);
    check("arb_ready", bus.instr_ready, 0);
    check("arb_done", bus.done, 0);
    tick();                                     // request still held
    check("arb_hold_grant", bus.ext_wr_grant, 1);
    bus.ext_wr_req = 1'b0;
    #1;
    check("arb_drop_ready", bus.instr_ready, 1);
    check("arb_drop_grant", bus.ext_wr_grant, 0);
    check("arb_drop_enable", bus.reg_enable, 0);
    tick();                                     // DECODE of 1234
    bus.instr_valid = 1'b0;
    check("arb_rd_sel_a", bus.rd_sel_a, 2);
    check("arb_alu_op", bus.alu_op, 8'h10);
    tick();                                     // EXEC, new request
    bus.ext_wr_req  = 1'b1;
    bus.ext_wr_addr = 4'h6;
    #1;
    check("arb_exec_grant", bus.ext_wr_grant, 0);
    check("arb_exec_enable", bus.reg_enable, 0);
    tick();                                     // WB
    check("arb_wb_grant", bus.ext_wr_grant, 0);
    check("arb_wb_done", bus.done, 1);
    check("arb_wb_enable", bus.reg_enable, 16'h0004);
    tick();                                     // IDLE: pending request granted
    check("arb_late_grant", bus.ext_wr_grant, 1);
    check("arb_late_enable", bus.reg_enable, 16'h0040);
    check("arb_late_bus_sel", bus.bus_sel, 1);
    bus.ext_wr_req = 1'b0;
    tick();

    // Reset during EXEC of 0910 aborts it.
    bus.instr       = 16'h0910;
    bus.instr_valid = 1'b1;
    bus.alu_ready   = 1'b0;
    tick();                                     // DECODE
    bus.instr_valid = 1'b0;
    check("abort_rd_sel_a", bus.rd_sel_a, 9);
    check("abort_alu_op", bus.alu_op, 8'h01);
    tick();                                     // EXEC
    reset = 1'b0;
    #1;
    check("abort_rd_sel_a_rst", bus.rd_sel_a, 0);
    check("abort_alu_op_rst", bus.alu_op, 0);
    check("abort_enable_rst", bus.reg_enable, 0);
    check("abort_done_rst", bus.done, 0);
    check("abort_ready_rst", bus.instr_ready, 0);
    tick();
    reset         = 1'b1;
    bus.alu_ready = 1'b1;
    en_seen  = '0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      en_seen = en_seen | bus.reg_enable;
      if (bus.done) done_cnt++;
      tick();
    end
    check("abort_enable_after", en_seen, 0);
    check("abort_done_after", done_cnt, 0);
    check("abort_ready_after", bus.instr_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
